regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-port register file with per-register pending-write scoreboard and optional execute/writeback bypass; the successor to the fixed 16×32 four-read-port file. It sits between decode/issue and the execute stage. Issue marks destinations pending, writeback commits and retires them, and each read port reports whether its operand is currently valid.

## Interface
Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 16, number of architectural registers (power of two, ≥2); register 0 reads zero.
- NREAD, 4, number of read ports.
- PEND_BITS, 2, width of each per-register pending-write counter.
- Derived: AW = $clog2(NREGS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  issue of an instruction that writes iss_addr.
- iss_addr  in  AW  destination being issued.
- iss_ready  out  1  issue accepted this cycle (combinational).
- fwd_addr  in  AW  execute-stage result address; 0 = none.
- fwd_data  in  WIDTH  execute-stage result.
- wb_addr  in  AW  writeback address; 0 = none.
- wb_data  in  WIDTH  writeback data.
- rd_addr  in  NREAD*AW  packed read addresses, port k at [k*AW +: AW].
- rd_data  out  NREAD*WIDTH  packed read data.
- rd_ready  out  NREAD  per-port operand valid.
- sb_err  out  1  sticky scoreboard underflow flag.

## Operation
- Storage: NREGS-1 registers, 1..NREGS-1; index 0 is constant zero, never pending, never written.
- Write: when wb_addr≠0, reg[wb_addr] ← wb_data at posedge.
- Scoreboard: cnt[r] is PEND_BITS wide, for r≠0.
- Issue fires when iss_valid & iss_ready & iss_addr≠0; cnt[iss_addr] += 1.
- iss_ready = 0 only when cnt[iss_addr] is all-ones and no retire to the same address happens this cycle. iss_addr=0 always ready and has no effect.
- Retire: wb_addr≠0 decrements cnt[wb_addr].
- Issue and retire to the same register in the same cycle leave the counter unchanged, including at saturation.
- Retire when the counter is 0: the write still occurs, the counter stays 0, and sb_err ← 1. sb_err clears only on rst.
- Read data priority with bypass: fwd hit (fwd_addr≠0 & fwd_addr==rd) > wb hit > stored value. rd=0 always returns 0.
- rd_ready with bypass: cnt[rd]==0, or cnt[rd]==1 & (fwd hit | wb hit). rd=0 is always ready.
- fwd_addr does not retire and never changes the scoreboard.

## Timing
- Reads (rd_data, rd_ready, iss_ready): combinational, zero latency.
- Writes and counter updates take effect at posedge; the stored value is visible to non-bypassed reads the next cycle.
- Issue-to-ready: a register issued in cycle n reads not-ready from cycle n+1 until its final retire (bypass: ready during the retire cycle).
- Reset: async assert clears all registers to 0, all counters to 0, and sb_err to 0.
- Reset outputs: rd_data reflects zeros or forwarded data, rd_ready all 1, iss_ready 1.
- Reset mid-operation discards all pending state immediately; no retire is pending afterwards.

## Configuration
- REGFILE_BYPASS_EN defined: fwd/wb bypass muxes and bypass rd_ready terms as above.
- REGFILE_BYPASS_EN undefined:
  - rd_data = stored value only; fwd_addr and fwd_data are ignored.
  - rd_ready = (cnt[rd]==0).
  - A register retired in cycle n is ready with correct data in cycle n+1.

## Structure
- Package regfile_pkg: default WIDTH, NREGS, NREAD, PEND_BITS constants; function computing AW; pend_t counter typedef.
- Sub-module regfile_bypass_port: one per read port. It takes the stored value, cnt, and the fwd/wb pairs, and produces data and ready. It is instantiated NREAD times under generate; without the macro it reduces to passthrough.

## Test plan
- Reset then read all registers on every port → data 0, rd_ready=1, iss_ready=1, sb_err=0.
- wb_addr=5, wb_data=32'hDEADBEEF → same cycle port 0 reads 5: bypass gives DEADBEEF, no-bypass gives stale 0; next cycle both give DEADBEEF.
- Issue r3, then fwd_addr=3/fwd_data=7 while wb_addr=3/wb_data=9 → bypass gives rd_data=7, rd_ready=1; reg[3] becomes 9 after posedge.
- PEND_BITS=2: issue r4 three times → cnt=3, iss_ready=0 for r4. A simultaneous issue+retire of r4 is accepted and cnt stays 3. Three retires → ready.
- Retire r6 with cnt=0 → reg[6] written, cnt stays 0, sb_err=1 and stays 1 until rst.
- Assert rst asynchronously with r2 pending and reg[2]=5 → rd_ready=1 and data 0 before the next clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the regfile_scoreboard slice.
//   Default geometry constants, the address-width helper and the default
//   pending-write counter type.
package regfile_pkg;

  localparam int unsigned DefaultWidth    = 32;
  localparam int unsigned DefaultNregs    = 16;
  localparam int unsigned DefaultNread    = 4;
  localparam int unsigned DefaultPendBits = 2;

  // Pending-write counter at the default width.
  typedef logic [DefaultPendBits-1:0] pend_t;

  // Register address width; a single-register file still needs one bit.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_bypass_port.sv
// regfile_bypass_port: one read port of regfile_scoreboard.
//   Resolves operand data and readiness from the stored value, the pending
//   counter and the execute/writeback result buses.
//   Build macro: REGFILE_BYPASS_EN enables the fwd/wb bypass; otherwise the
//   port passes the stored value through and is ready only with no writes
//   outstanding.
// Ports:
//   rd_addr_i  read address
//   stored_i   architectural value of rd_addr_i
//   cnt_i      pending-write count of rd_addr_i
//   fwd_*_i    execute-stage result (addr 0 = none)
//   wb_*_i     writeback result (addr 0 = none)
//   data_o     operand data
//   ready_o    operand valid
module regfile_bypass_port #(
  parameter int unsigned Width     = 32,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned PendBits  = 2
) (
  input  logic [AddrWidth-1:0] rd_addr_i,
  input  logic [Width-1:0]     stored_i,
  input  logic [PendBits-1:0]  cnt_i,
  input  logic [AddrWidth-1:0] fwd_addr_i,
  input  logic [Width-1:0]     fwd_data_i,
  input  logic [AddrWidth-1:0] wb_addr_i,
  input  logic [Width-1:0]     wb_data_i,
  output logic [Width-1:0]     data_o,
  output logic                 ready_o
);

  logic rd_zero;
  assign rd_zero = (rd_addr_i == '0);

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;
  logic wb_hit;

  assign fwd_hit = (fwd_addr_i != '0) && (fwd_addr_i == rd_addr_i);
  assign wb_hit  = (wb_addr_i != '0) && (wb_addr_i == rd_addr_i);

  always_comb begin
    data_o = stored_i;
    if (rd_zero) begin
      data_o = '0;
    end else if (fwd_hit) begin
      data_o = fwd_data_i;
    end else if (wb_hit) begin
      data_o = wb_data_i;
    end
  end

  // The last outstanding write may be satisfied by a result on either bus.
  assign ready_o = rd_zero || (cnt_i == '0) ||
                   ((cnt_i == PendBits'(1)) && (fwd_hit || wb_hit));
`else
  logic unused_bypass;
  assign unused_bypass = ^{fwd_addr_i, fwd_data_i, wb_addr_i, wb_data_i};

  assign data_o  = rd_zero ? '0 : stored_i;
  assign ready_o = rd_zero || (cnt_i == '0);
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised multi-port register file with a per-register
//   pending-write scoreboard and optional execute/writeback bypass.
//   Build macro: REGFILE_BYPASS_EN enables the bypass paths in each read port.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   iss_valid/addr  issue of an instruction writing iss_addr
//   iss_ready       issue accepted (combinational)
//   fwd_addr/data   execute-stage result, addr 0 = none; never retires
//   wb_addr/data    writeback, addr 0 = none; writes and retires
//   rd_addr         NREAD packed read addresses, port k at [k*AW +: AW]
//   rd_data         NREAD packed read data
//   rd_ready        per-port operand valid
//   sb_err          sticky flag: retire seen with no write pending
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned NREGS     = DefaultNregs,
  parameter int unsigned NREAD     = DefaultNread,
  parameter int unsigned PEND_BITS = DefaultPendBits,
  localparam int unsigned AW       = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  output logic                   iss_ready,
  input  logic [AW-1:0]          fwd_addr,
  input  logic [WIDTH-1:0]       fwd_data,
  input  logic [AW-1:0]          wb_addr,
  input  logic [WIDTH-1:0]       wb_data,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_ready,
  output logic                   sb_err
);

  // Entry 0 of both arrays is held at zero and optimises away.
  logic [WIDTH-1:0]     regs_q [NREGS];
  logic [WIDTH-1:0]     regs_d [NREGS];
  logic [PEND_BITS-1:0] cnt_q  [NREGS];
  logic [PEND_BITS-1:0] cnt_d  [NREGS];
  logic                 sb_err_q, sb_err_d;

  logic retire;
  logic iss_fire;
  logic same_reg;

  assign retire   = (wb_addr != '0);
  assign same_reg = retire && (wb_addr == iss_addr);

  // A retire to the same register frees a slot in the same cycle.
  assign iss_ready = (iss_addr == '0) || !(&cnt_q[iss_addr]) || same_reg;
  assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);

  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;

    if (retire) begin
      regs_d[wb_addr] = wb_data;
    end

    // Simultaneous issue and retire of one register cancel out.
    if (iss_fire && !same_reg) begin
      cnt_d[iss_addr] = cnt_q[iss_addr] + PEND_BITS'(1);
    end
    if (retire && !(iss_fire && same_reg)) begin
      if (cnt_q[wb_addr] == '0) begin
        sb_err_d = 1'b1;
      end else begin
        cnt_d[wb_addr] = cnt_q[wb_addr] - PEND_BITS'(1);
      end
    end

    regs_d[0] = '0;
    cnt_d[0]  = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
    logic [AW-1:0] port_addr;
    assign port_addr = rd_addr[k*AW +: AW];

    regfile_bypass_port #(
      .Width    (WIDTH),
      .AddrWidth(AW),
      .PendBits (PEND_BITS)
    ) u_port (
      .rd_addr_i (port_addr),
      .stored_i  (regs_q[port_addr]),
      .cnt_i     (cnt_q[port_addr]),
      .fwd_addr_i(fwd_addr),
      .fwd_data_i(fwd_data),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .data_o    (rd_data[k*WIDTH +: WIDTH]),
      .ready_o   (rd_ready[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard at default geometry (32x16, 4 ports,
// 2-bit counters). Expectations follow the REGFILE_BYPASS_EN build setting.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [3:0]  iss_addr;
  logic        iss_ready;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_ready;
  logic        sb_err;

  int checks   = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .iss_ready(iss_ready),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .sb_err   (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input int k, input logic [3:0] a);
    rd_addr[k*4 +: 4] = a;
  endtask

  function automatic logic [31:0] port_data(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  initial begin
    rst = 1'b1; iss_valid = 1'b0; iss_addr = '0;
    fwd_addr = '0; fwd_data = '0; wb_addr = '0; wb_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_sb_err", 32'(sb_err), 32'd0);

    // Every register on every port reads zero and ready after reset.
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) set_rd(k, 4'(r));
      iss_addr = 4'(r);
      #1;
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("rst_data_r%0d_p%0d", r, k), port_data(k), 32'd0);
        check_eq($sformatf("rst_rdy_r%0d_p%0d", r, k), 32'(rd_ready[k]), 32'd1);
      end
      check_eq($sformatf("rst_iss_ready_r%0d", r), 32'(iss_ready), 32'd1);
    end
    rd_addr = '0;
    iss_addr = '0;

    // Writeback visibility on r5.
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 4'd5; set_rd(0, 4'd5);
    #1 check_eq("r5_rdy_issue_cycle", 32'(rd_ready[0]), 32'd1);
    @(negedge clk);
    iss_valid = 1'b0;
    #1 check_eq("r5_rdy_pending", 32'(rd_ready[0]), 32'd0);
    @(negedge clk);
    wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    #1;
    check_eq("r5_data_wb_cycle", port_data(0), Bypass ? 32'hDEADBEEF : 32'd0);
    check_eq("r5_rdy_wb_cycle", 32'(rd_ready[0]), Bypass ? 32'd1 : 32'd0);
    @(negedge clk);
    wb_addr = '0;
    #1;
    check_eq("r5_data_after", port_data(0), 32'hDEADBEEF);
    check_eq("r5_rdy_after", 32'(rd_ready[0]), 32'd1);
    check_eq("r5_sb_err", 32'(sb_err), 32'd0);

    // Forward beats writeback on r3.
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 4'd3; set_rd(1, 4'd3);
    @(negedge clk);
    iss_valid = 1'b0;
    fwd_addr = 4'd3; fwd_data = 32'd7; wb_addr = 4'd3; wb_data = 32'd9;
    #1;
    check_eq("r3_data_fwd_wb", port_data(1), Bypass ? 32'd7 : 32'd0);
    check_eq("r3_rdy_fwd_wb", 32'(rd_ready[1]), Bypass ? 32'd1 : 32'd0);
    @(negedge clk);
    wb_addr = '0;
    #1;
    check_eq("r3_data_fwd_only", port_data(1), Bypass ? 32'd7 : 32'd9);
    check_eq("r3_rdy_fwd_only", 32'(rd_ready[1]), 32'd1);
    @(negedge clk);
    fwd_addr = '0;
    #1 check_eq("r3_data_stored", port_data(1), 32'd9);

    // Counter saturation on r4.
    set_rd(2, 4'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iss_valid = 1'b1; iss_addr = 4'd4;
      #1 check_eq($sformatf("r4_iss_ready_%0d", i), 32'(iss_ready), 32'd1);
    end
    @(negedge clk);
    #1;
    check_eq("r4_iss_ready_full", 32'(iss_ready), 32'd0);
    check_eq("r4_rdy_full", 32'(rd_ready[2]), 32'd0);
    @(negedge clk);
    wb_addr = 4'd4; wb_data = 32'h44;
    #1 check_eq("r4_iss_ready_swap", 32'(iss_ready), 32'd1);
    @(negedge clk);
    wb_addr = '0;
    #1 check_eq("r4_iss_ready_still_full", 32'(iss_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iss_valid = 1'b0; wb_addr = 4'd4; wb_data = 32'h100 + 32'(i);
      #1 check_eq($sformatf("r4_rdy_retire_%0d", i), 32'(rd_ready[2]),
                  (i == 2 && Bypass) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    wb_addr = '0;
    #1;
    check_eq("r4_rdy_drained", 32'(rd_ready[2]), 32'd1);
    check_eq("r4_data_drained", port_data(2), 32'h102);
    check_eq("r4_sb_err", 32'(sb_err), 32'd0);

    // Underflow on r6.
    @(negedge clk);
    wb_addr = 4'd6; wb_data = 32'h66; set_rd(3, 4'd6);
    #1 check_eq("r6_sb_err_before", 32'(sb_err), 32'd0);
    @(negedge clk);
    wb_addr = '0; iss_addr = 4'd6;
    #1;
    check_eq("r6_sb_err_set", 32'(sb_err), 32'd1);
    check_eq("r6_data", port_data(3), 32'h66);
    check_eq("r6_rdy", 32'(rd_ready[3]), 32'd1);
    check_eq("r6_iss_ready", 32'(iss_ready), 32'd1);
    repeat (3) @(negedge clk);
    #1 check_eq("r6_sb_err_sticky", 32'(sb_err), 32'd1);

    // Asynchronous reset with r2 pending.
    set_rd(0, 4'd2);
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 4'd2;
    @(negedge clk);
    @(negedge clk);
    iss_valid = 1'b0; wb_addr = 4'd2; wb_data = 32'd5;
    @(negedge clk);
    wb_addr = '0;
    #1;
    check_eq("r2_data_pre_rst", port_data(0), 32'd5);
    check_eq("r2_rdy_pre_rst", 32'(rd_ready[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("r2_data_async_rst", port_data(0), 32'd0);
    check_eq("r2_rdy_async_rst", 32'(rd_ready[0]), 32'd1);
    check_eq("r3_data_async_rst", port_data(1), 32'd0);
    check_eq("sb_err_async_rst", 32'(sb_err), 32'd0);
    check_eq("r2_iss_ready_async_rst", 32'(iss_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; wb_addr = 4'd2; wb_data = 32'h22;
    #1 check_eq("r2_rdy_post_rst", 32'(rd_ready[0]), 32'd1);
    @(negedge clk);
    wb_addr = '0;
    #1;
    check_eq("r2_sb_err_post_rst", 32'(sb_err), 32'd1);
    check_eq("r2_data_post_rst", port_data(0), 32'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
